// File: rtl/spi_fpga_master_multi_cs.sv
// rtl/spi_fpga_master_multi_cs.sv - SPI master with per-transaction chip-select decode for NUM_SLAVES slaves
// Sequence per transfer: SETUP, SHIFT, HOLD with the selected CS low, then a GAP with all CS high.

module spi_fpga_master_multi_cs #(
   parameter int   CLOCK_FREQUENCY            = 50000000,
   parameter int   BIT_PER_SECOND             = 12500000,
   parameter int   PACK_LENGTH                = 8,
   parameter int   NUM_SLAVES                 = 2,
   parameter int   SLAVE_INDEX_WIDTH          = $clog2(NUM_SLAVES + 1),
   parameter logic CPOL                       = 1'b0,
   parameter logic CPHA                       = 1'b0,
   parameter int   PACK_BIT_SEQUENCE_TRANSMIT = 1,
   parameter int   PACK_BIT_SEQUENCE_RECEIVE  = 1,
   parameter int   CS_IDLE_CYCLES             = 4
) (
   input  logic                         IN_CLOCK,
   input  logic                         IN_RESET,
   input  logic                         IN_LAUNCH,
   input  logic [SLAVE_INDEX_WIDTH-1:0] IN_SLAVE_INDEX,
   input  logic [PACK_LENGTH-1:0]       IN_DATA,
   input  logic                         IN_MISO,
   output logic                         OUT_MOSI,
   output logic                         OUT_SCLK,
   output logic [NUM_SLAVES-1:0]        OUT_CS,
   output logic [PACK_LENGTH-1:0]       OUT_RECEIVE_DATA,
   output logic                         OUT_ACTION_DONE,
   output logic                         OUT_BUSY,
   output logic                         OUT_INVALID_INDEX
);

   localparam logic [31:0] HALF    = 32'(CLOCK_FREQUENCY / (2 * BIT_PER_SECOND));
   localparam logic [31:0] PL      = 32'(PACK_LENGTH);
   localparam logic [31:0] EDGES   = 32'(2 * PACK_LENGTH);
   localparam logic [31:0] GAP_LEN = 32'(CS_IDLE_CYCLES);
   localparam int          IW      = (PACK_LENGTH > 1) ? $clog2(PACK_LENGTH) : 1;
   localparam logic        TX_MSB  = (PACK_BIT_SEQUENCE_TRANSMIT != 0);
   localparam logic        RX_MSB  = (PACK_BIT_SEQUENCE_RECEIVE != 0);

   typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP} state_t;

   state_t                  state_q, state_d;
   logic [31:0]             cnt_q, cnt_d;
   logic [31:0]             edge_q, edge_d;
   logic [PACK_LENGTH-1:0]  tx_q, tx_d;
   logic [PACK_LENGTH-1:0]  rx_sh_q, rx_sh_d;
   logic [PACK_LENGTH-1:0]  rx_data_q, rx_data_d;
   logic [NUM_SLAVES-1:0]   cs_q, cs_d;
   logic                    sclk_q, sclk_d;
   logic                    mosi_q, mosi_d;
   logic                    done_q, done_d;
   logic                    busy_q, busy_d;
   logic                    inv_q, inv_d;
   logic [31:0]             next_bit;

   // Maps the i-th serial bit to its word position for the chosen bit order.
   function automatic logic [IW-1:0] bit_pos(input logic msb_first, input logic [31:0] i);
      return msb_first ? IW'(PL - 32'd1 - i) : IW'(i);
   endfunction

   always_ff @(posedge IN_CLOCK or posedge IN_RESET) begin
      if (IN_RESET) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         edge_q    <= '0;
         tx_q      <= '0;
         rx_sh_q   <= '0;
         rx_data_q <= '0;
         cs_q      <= '1;
         sclk_q    <= CPOL;
         mosi_q    <= 1'b0;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
         inv_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         edge_q    <= edge_d;
         tx_q      <= tx_d;
         rx_sh_q   <= rx_sh_d;
         rx_data_q <= rx_data_d;
         cs_q      <= cs_d;
         sclk_q    <= sclk_d;
         mosi_q    <= mosi_d;
         done_q    <= done_d;
         busy_q    <= busy_d;
         inv_q     <= inv_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      edge_d    = edge_q;
      tx_d      = tx_q;
      rx_sh_d   = rx_sh_q;
      rx_data_d = rx_data_q;
      cs_d      = cs_q;
      sclk_d    = sclk_q;
      mosi_d    = mosi_q;
      done_d    = 1'b0;
      busy_d    = busy_q;
      inv_d     = 1'b0;
      next_bit  = '0;
      case (state_q)
         S_IDLE: begin
            if (IN_LAUNCH) begin
               if (32'(IN_SLAVE_INDEX) < 32'(NUM_SLAVES)) begin
                  tx_d    = IN_DATA;
                  rx_sh_d = '0;
                  for (int i = 0; i < NUM_SLAVES; i++) begin
                     cs_d[i] = (32'(IN_SLAVE_INDEX) != 32'(i));
                  end
                  mosi_d  = CPHA ? 1'b0 : IN_DATA[bit_pos(TX_MSB, 32'd0)];
                  busy_d  = 1'b1;
                  cnt_d   = '0;
                  edge_d  = '0;
                  state_d = S_SETUP;
               end else begin
                  inv_d = 1'b1;
               end
            end
         end
         S_SETUP: begin
            if (cnt_q == HALF - 32'd1) begin
               cnt_d   = '0;
               state_d = S_SHIFT;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         S_SHIFT: begin
            if (cnt_q == HALF - 32'd1) begin
               cnt_d  = '0;
               sclk_d = ~sclk_q;
               edge_d = edge_q + 32'd1;
               // Even edge index is the leading edge; CPHA picks which one samples.
               if (edge_q[0] == CPHA) begin
                  rx_sh_d[bit_pos(RX_MSB, edge_q >> 1)] = IN_MISO;
               end else begin
                  next_bit = CPHA ? (edge_q >> 1) : ((edge_q + 32'd1) >> 1);
                  if (next_bit < PL) begin
                     mosi_d = tx_q[bit_pos(TX_MSB, next_bit)];
                  end
               end
               if (edge_q == EDGES - 32'd1) begin
                  state_d = S_HOLD;
               end
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         S_HOLD: begin
            if (cnt_q == HALF - 32'd1) begin
               cnt_d     = '0;
               cs_d      = '1;
               rx_data_d = rx_sh_q;
               done_d    = 1'b1;
               mosi_d    = 1'b0;
               state_d   = S_GAP;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         S_GAP: begin
            if (cnt_q == GAP_LEN - 32'd1) begin
               cnt_d   = '0;
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign OUT_MOSI          = mosi_q;
   assign OUT_SCLK          = sclk_q;
   assign OUT_CS            = cs_q;
   assign OUT_RECEIVE_DATA  = rx_data_q;
   assign OUT_ACTION_DONE   = done_q;
   assign OUT_BUSY          = busy_q;
   assign OUT_INVALID_INDEX = inv_q;

endmodule

// File: doc/spi_fpga_master_multi_cs.md
Name: spi_fpga_master_multi_cs

Overview:
Parametrised SPI master with an integrated chip-select decoder for up to NUM_SLAVES slaves. Successor to the single-CS SPI_FPGA_MASTER: the target slave is selected per transaction, invalid indices are rejected, all four SPI modes are supported, and back-to-back bursts are possible. It sits between user logic and a shared MOSI/MISO/SCLK bus, driving one active-low CS line per slave.

Parameters:
CLOCK_FREQUENCY, 50000000, system clock in Hz.
BIT_PER_SECOND, 12500000, SCLK bit rate. HALF = CLOCK_FREQUENCY/(2*BIT_PER_SECOND) must be an integer >= 1 (default 2).
PACK_LENGTH, 8, bits per transaction (>= 2).
NUM_SLAVES, 2, number of CS lines (>= 1).
SLAVE_INDEX_WIDTH, $clog2(NUM_SLAVES+1), width of the slave-index input.
CPOL, 1'b0, SCLK idle level.
CPHA, 1'b0, 0 = sample on leading edge, 1 = sample on trailing edge.
PACK_BIT_SEQUENCE_TRANSMIT, 1, 1 = MSB first, 0 = LSB first.
PACK_BIT_SEQUENCE_RECEIVE, 1, 1 = MSB first, 0 = LSB first.
CS_IDLE_CYCLES, 4, minimum number of clocks all CS lines stay high between transactions (>= 1).

Ports:
IN_CLOCK  input  1  system clock
IN_RESET  input  1  asynchronous, active-high reset
IN_LAUNCH  input  1  start request, level-sampled in IDLE
IN_SLAVE_INDEX  input  SLAVE_INDEX_WIDTH  target slave, 0..NUM_SLAVES-1
IN_DATA  input  PACK_LENGTH  word to transmit
IN_MISO  input  1  serial data from slaves
OUT_MOSI  output  1  serial data to slaves
OUT_SCLK  output  1  serial clock
OUT_CS  output  NUM_SLAVES  active-low chip selects, one-hot-low when active
OUT_RECEIVE_DATA  output  PACK_LENGTH  last received word
OUT_ACTION_DONE  output  1  one-clock pulse at the end of a transaction
OUT_BUSY  output  1  high from the launch-accept clock until the end of GAP
OUT_INVALID_INDEX  output  1  one-clock pulse when a launch is rejected

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-transfer): state IDLE; OUT_CS all 1; OUT_SCLK = CPOL; OUT_MOSI = 0; OUT_RECEIVE_DATA = 0; OUT_ACTION_DONE, OUT_BUSY and OUT_INVALID_INDEX all 0; all counters 0.
- IDLE: on a clock edge where IN_LAUNCH = 1:
  - If IN_SLAVE_INDEX < NUM_SLAVES: latch IN_DATA and IN_SLAVE_INDEX, go to SETUP, and set OUT_BUSY = 1.
  - Otherwise: pulse OUT_INVALID_INDEX for one clock, drive no CS, no SCLK edges and no done pulse, and stay in IDLE.
- SETUP (HALF clocks): the selected OUT_CS bit is low from the first clock of SETUP. When CPHA = 0, OUT_MOSI carries the first TX bit throughout SETUP.
- SHIFT (2*PACK_LENGTH*HALF clocks):
  - OUT_SCLK toggles every HALF clocks, giving PACK_LENGTH full SCLK periods.
  - CPHA = 0: sample IN_MISO on the leading edge; update OUT_MOSI on the trailing edge.
  - CPHA = 1: update OUT_MOSI on the leading edge; sample on the trailing edge.
  - Bit order is selected by the PACK_BIT_SEQUENCE_* parameters.
  - OUT_SCLK returns to CPOL after the last edge.
- HOLD (HALF clocks): CS is still low and SCLK is idle.
- End of HOLD:
  - CS goes high.
  - OUT_RECEIVE_DATA updates and OUT_ACTION_DONE pulses, both in the same clock.
  - Go to GAP.
- GAP (CS_IDLE_CYCLES clocks): all CS high, then return to IDLE with OUT_BUSY = 0.
  - If IN_LAUNCH is still 1 in IDLE, the next transaction starts immediately. Holding launch high therefore produces a burst.
- CS-low duration = (2*PACK_LENGTH + 2)*HALF clocks; this is 36 clocks at the defaults.
- IN_DATA and IN_SLAVE_INDEX changes while busy do not affect the transfer in progress.
- At most one OUT_CS bit is low at any time. OUT_RECEIVE_DATA holds its value until the next completed transaction.

Test Plan:
1. NUM_SLAVES = 2, mode 0, index 0, IN_DATA = 8'hEA; slave 0 model returns 8'h53 -> OUT_CS = 2'b10 for exactly 36 clocks, 8 rising SCLK edges, slave receives 8'hEA, OUT_RECEIVE_DATA = 8'h53, one OUT_ACTION_DONE pulse.
2. Index 1, IN_DATA = 8'hE3; slave 1 returns 8'hAA -> OUT_CS = 2'b01, slave 1 receives 8'hE3, OUT_RECEIVE_DATA = 8'hAA; slave 0 sees no CS.
3. Index 3 (invalid) with IN_LAUNCH = 1 -> OUT_CS stays 2'b11, no SCLK activity, one OUT_INVALID_INDEX pulse, no OUT_ACTION_DONE, OUT_BUSY stays 0, OUT_RECEIVE_DATA unchanged.
4. IN_LAUNCH held high across two transactions to index 0 (8'h0F then 8'hF0) -> two done pulses; CS high for exactly CS_IDLE_CYCLES + 1 clocks between the CS-low windows.
5. CPOL = 1, CPHA = 1, LSB first on both TX and RX; send 8'h01, slave returns 8'h80 -> SCLK idles high, the first MOSI bit is 1, OUT_RECEIVE_DATA = 8'h80.
6. Assert IN_RESET during bit 4 of a transfer -> OUT_CS = all 1, OUT_SCLK = CPOL, OUT_BUSY = 0 without waiting for a clock edge; no done pulse; a fresh launch after reset completes correctly.
